// File: rtl/spi_mnrch_param.sv
`timescale 1ns/1ps
// spi_mnrch_param: parametrised SPI mode-3 monarch (master).
// One frame of WIDTH bits per accepted wrt, MSB first, SCLK period 2^DIV_LOG2 clk,
// NUM_SS active-low selects, H-cycle porches before/after the bit train and an
// H-cycle inter-frame SS_n gap. rd_data updates only when a frame completes.
// Optional build macro SPI_MNRCH_MISO_SYNC2_EN: two-flop MISO synchroniser
// instead of a single flop (only the MISO sampling latency changes).
module spi_mnrch_param #(
  parameter int WIDTH    = 16,
  parameter int DIV_LOG2 = 4,
  parameter int NUM_SS   = 1,
  localparam int SSW     = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt,
  input  logic [WIDTH-1:0]  wt_data,
  input  logic [SSW-1:0]    ss_sel,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_SS-1:0] SS_n,
  output logic [WIDTH-1:0]  rd_data,
  output logic              done,
  output logic              busy
);

  localparam int HW = DIV_LOG2 - 1;        // half-period counter width, H = 2^HW
  localparam int BW = $clog2(WIDTH) + 1;   // rising-edge counter width

  typedef enum logic [2:0] {IDLE, PORCH_F, XFER, PORCH_B, GAP} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              sample_q, sample_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              half_end;

`ifdef SPI_MNRCH_MISO_SYNC2_EN
  logic miso_meta_q, miso_meta_d;
  logic miso_sync_q, miso_sync_d;

  // Two-stage synchroniser input selection.
  always_comb begin
    miso_meta_d = MISO;
    miso_sync_d = miso_meta_q;
  end

  // Two-stage synchroniser registers.
  always_ff @(posedge clk) begin
    miso_meta_q <= miso_meta_d;
    miso_sync_q <= miso_sync_d;
  end
`else
  logic miso_sync_q, miso_sync_d;

  // Single-stage synchroniser input selection.
  always_comb miso_sync_d = MISO;

  // Single-stage synchroniser register.
  always_ff @(posedge clk) begin
    miso_sync_q <= miso_sync_d;
  end
`endif

  // The half-period counter wraps to zero on its last count, so every phase starts fresh.
  assign half_end = (cnt_q == {HW{1'b1}});

  // Next-state, SCLK/MOSI/SS_n sequencing and shift-register updates.
  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case leaves a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sample_d  = sample_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    rd_data_d = rd_data_q;
    done_d    = done_q;
    busy_d    = busy_q;

    if (state_q != IDLE) cnt_d = cnt_q + HW'(1);

    case (state_q)
      IDLE: begin
        if (wrt) begin
          shreg_d   = wt_data;
          mosi_d    = wt_data[WIDTH-1];
          ss_n_d    = '1;
          for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SSW'(i)) ss_n_d[i] = 1'b0;
          end
          cnt_d     = '0;
          bit_cnt_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = PORCH_F;
        end
      end
      PORCH_F: begin
        // First fall: MOSI already holds the MSB, so nothing shifts here.
        if (half_end) begin
          sclk_d  = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (half_end) begin
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            sample_d  = miso_sync_q;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (bit_cnt_q == BW'(WIDTH)) begin
            state_d = PORCH_B;
          end else begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[WIDTH-2:0], sample_q};
            mosi_d  = shreg_q[WIDTH-2];
          end
        end
      end
      PORCH_B: begin
        if (half_end) begin
          rd_data_d = {shreg_q[WIDTH-2:0], sample_q};
          done_d    = 1'b1;
          ss_n_d    = '1;
          mosi_d    = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (half_end) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so all flops update from pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
      rd_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset needed: shreg is loaded on accept and sample is written before any use.
    shreg_q  <= shreg_d;
    sample_q <= sample_d;
  end

  assign MOSI    = mosi_q;
  assign SCLK    = sclk_q;
  assign SS_n    = ss_n_q;
  assign rd_data = rd_data_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule
